// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word reads, holds one instruction for decode,
// and handles redirects (including misaligned targets) while a read is in flight.
module instruction_fetch #(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        step,
  input  logic        jump,
  input  logic [31:0] jumpAddress,
  output logic        memRequest,
  output logic [31:0] memAddress,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic [31:0] currentInstruction,
  output logic        isNOP,
  output logic [31:0] programCounter,
  output logic        addressMisaligned
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_VALID = 3'd1,
    S_FLUSH = 3'd2,
    S_FAULT = 3'd3,
    S_IDLE  = 3'd4
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] flush_addr_reg;
  logic        misaligned_reg;
  logic        issued_reg;
  logic        fault_pending_reg;

  logic jump_aligned;
  logic jump_misaligned;
  logic fetch_stalled;

  assign jump_aligned    = jump && (jumpAddress[1:0] == 2'b00);
  assign jump_misaligned = jump && (jumpAddress[1:0] != 2'b00);
  // A read that is out on the bus but not yet answered must be drained before redirecting.
  assign fetch_stalled   = (state_reg == S_FETCH) && memRequest && !memReady;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= enable ? S_FETCH : S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (jump) begin
      if (fetch_stalled || ((state_reg == S_FLUSH) && !memReady)) begin
        state_next = S_FLUSH;
      end else begin
        state_next = jump_aligned ? S_FETCH : S_FAULT;
      end
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (!memRequest) begin
            state_next = S_IDLE;
          end else if (memReady) begin
            state_next = S_VALID;
          end
        end
        S_VALID: begin
          if (step) begin
            state_next = enable ? S_FETCH : S_IDLE;
          end
        end
        S_FLUSH: begin
          if (memReady) begin
            state_next = fault_pending_reg ? S_FAULT : S_FETCH;
          end
        end
        S_FAULT: state_next = S_FAULT;
        S_IDLE: begin
          if (enable) begin
            state_next = S_FETCH;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    memRequest = 1'b0;
    memAddress = pc_reg;
    if (state_reg == S_FLUSH) begin
      memAddress = flush_addr_reg;
    end
    if (!rst) begin
      case (state_reg)
        S_FETCH: memRequest = enable || issued_reg;
        S_FLUSH: memRequest = 1'b1;
        default: memRequest = 1'b0;
      endcase
    end
  end

  assign isNOP              = (state_reg != S_VALID);
  assign currentInstruction = instr_reg;
  assign programCounter     = pc_reg;
  assign addressMisaligned  = misaligned_reg;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg            <= RESET_ADDRESS;
      instr_reg         <= 32'h0;
      flush_addr_reg    <= RESET_ADDRESS;
      misaligned_reg    <= 1'b0;
      issued_reg        <= 1'b0;
      fault_pending_reg <= 1'b0;
    end else begin
      issued_reg <= fetch_stalled && !jump;
      if (jump) begin
        pc_reg            <= jumpAddress;
        misaligned_reg    <= jump_misaligned;
        fault_pending_reg <= jump_misaligned;
        // Only a redirect out of FETCH changes which address the drain must keep presenting.
        if (state_reg == S_FETCH) begin
          flush_addr_reg <= pc_reg;
        end
      end else begin
        case (state_reg)
          S_FETCH: begin
            if (memRequest && memReady) begin
              instr_reg <= memData;
            end
          end
          S_VALID: begin
            if (step) begin
              pc_reg <= pc_reg + 32'd4;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a memory model answers requests and a
// scoreboard of expected (pc, instruction) pairs is checked each time decode sees a new instruction.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        step;
  logic        jump;
  logic [31:0] jumpAddress;
  logic        memRequest;
  logic [31:0] memAddress;
  logic        memReady;
  logic [31:0] memData;
  logic [31:0] currentInstruction;
  logic        isNOP;
  logic [31:0] programCounter;
  logic        addressMisaligned;

  instruction_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .step               (step),
    .jump               (jump),
    .jumpAddress        (jumpAddress),
    .memRequest         (memRequest),
    .memAddress         (memAddress),
    .memReady           (memReady),
    .memData            (memData),
    .currentInstruction (currentInstruction),
    .isNOP              (isNOP),
    .programCounter     (programCounter),
    .addressMisaligned  (addressMisaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   lat      = 0;
  int   wait_cnt = 0;
  bit   spurious = 1'b0;
  bit   prev_nop = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[29:0], 2'b11} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_instr(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    sb.push_back(e);
  endtask

  // Memory model: answers a request after lat wait cycles; optionally pulses memReady with no request.
  task automatic respond();
    if (memRequest) begin
      if (wait_cnt >= lat) begin
        memReady = 1'b1;
        memData  = mem_word(memAddress);
        wait_cnt = 0;
      end else begin
        memReady = 1'b0;
        memData  = 32'hDEAD_BEEF;
        wait_cnt++;
      end
    end else begin
      memReady = spurious;
      memData  = 32'hDEAD_BEEF;
      wait_cnt = 0;
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (!isNOP && prev_nop) begin
      check("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("valid_pc", programCounter, e.pc);
        check("valid_instr", currentInstruction, e.instr);
        $display("[TB] fetched pc=%h instr=%h", programCounter, currentInstruction);
      end
    end
    prev_nop = isNOP;
  endtask

  task automatic cycle();
    #1;
    respond();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) cycle();
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; enable = 1'b1; step = 1'b0; jump = 1'b0; jumpAddress = 32'h0;
    memReady = 1'b0; memData = 32'h0;
    cycle();
    cycle();
    check("rst_memreq", 32'(memRequest), 32'd0);
    check("rst_isnop", 32'(isNOP), 32'd1);
    check("rst_pc", programCounter, 32'h0);
    check("rst_instr", currentInstruction, 32'h0);
    check("rst_misal", 32'(addressMisaligned), 32'd0);

    // First fetch from reset address, single-cycle memory
    rst = 1'b0;
    expect_instr(32'h0);
    #1;
    check("first_req", 32'(memRequest), 32'd1);
    check("first_addr", memAddress, 32'h0);
    drain(4);
    check("first_isnop", 32'(isNOP), 32'd0);

    // Hold without step
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_req", 32'(memRequest), 32'd0);
      check("hold_nop", 32'(isNOP), 32'd0);
      check("hold_instr", currentInstruction, 32'h0050_0093);
      check("hold_pc", programCounter, 32'h0);
    end
    step = 1'b1;
    expect_instr(32'h4);
    cycle();
    check("step_addr", memAddress, 32'h4);
    check("step_req", 32'(memRequest), 32'd1);
    drain(10);
    step = 1'b0;

    // Throughput: six instructions, two cycles each
    step = 1'b1;
    for (int i = 1; i <= 6; i++) expect_instr(32'h4 + 32'(4 * i));
    cnt = 0;
    while (sb.size() != 0 && cnt < 50) begin
      cycle();
      cnt++;
    end
    step = 1'b0;
    check("throughput_cycles", 32'(cnt), 32'd12);

    // Redirect while a read is outstanding
    lat = 3;
    jump = 1'b1; jumpAddress = 32'h10;
    cycle();
    check("j10_addr", memAddress, 32'h10);
    check("j10_req", 32'(memRequest), 32'd1);
    jumpAddress = 32'h100;
    expect_instr(32'h100);
    cycle();
    jump = 1'b0;
    for (int i = 0; i < 10 && memAddress != 32'h100; i++) begin
      check("flush_addr", memAddress, 32'h10);
      check("flush_req", 32'(memRequest), 32'd1);
      check("flush_nop", 32'(isNOP), 32'd1);
      cycle();
    end
    check("redirect_addr", memAddress, 32'h100);
    check("redirect_req", 32'(memRequest), 32'd1);
    drain(20);

    // Misaligned target from VALID
    lat = 0;
    jump = 1'b1; jumpAddress = 32'h102;
    cycle();
    jump = 1'b0; step = 1'b1;
    check("mis_flag", 32'(addressMisaligned), 32'd1);
    check("mis_nop", 32'(isNOP), 32'd1);
    check("mis_pc", programCounter, 32'h102);
    check("mis_req", 32'(memRequest), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("fault_req", 32'(memRequest), 32'd0);
      check("fault_flag", 32'(addressMisaligned), 32'd1);
    end
    step = 1'b0;
    jump = 1'b1; jumpAddress = 32'h200;
    expect_instr(32'h200);
    cycle();
    jump = 1'b0;
    check("unfault_flag", 32'(addressMisaligned), 32'd0);
    check("unfault_req", 32'(memRequest), 32'd1);
    check("unfault_addr", memAddress, 32'h200);
    drain(10);

    // Misaligned target while a read is outstanding: drain first, then fault
    lat = 3;
    jump = 1'b1; jumpAddress = 32'h300;
    cycle();
    jumpAddress = 32'h306;
    cycle();
    jump = 1'b0;
    check("mdrain_flag", 32'(addressMisaligned), 32'd1);
    check("mdrain_req", 32'(memRequest), 32'd1);
    check("mdrain_addr", memAddress, 32'h300);
    for (int i = 0; i < 10 && memRequest; i++) cycle();
    check("mdrain_done_req", 32'(memRequest), 32'd0);
    check("mdrain_pc", programCounter, 32'h306);
    check("mdrain_nop", 32'(isNOP), 32'd1);
    check("mdrain_flag2", 32'(addressMisaligned), 32'd1);

    // Program counter wrap, also leaving FAULT via aligned jump
    lat = 0;
    jump = 1'b1; jumpAddress = 32'hFFFF_FFFC;
    expect_instr(32'hFFFF_FFFC);
    expect_instr(32'h0);
    cycle();
    jump = 1'b0; step = 1'b1;
    check("wrap_flag", 32'(addressMisaligned), 32'd0);
    drain(10);
    step = 1'b0;

    // Enable low: go IDLE, ignore memReady with no request
    enable = 1'b0; step = 1'b1;
    cycle();
    step = 1'b0;
    check("idle_req", 32'(memRequest), 32'd0);
    check("idle_pc", programCounter, 32'h4);
    check("idle_nop", 32'(isNOP), 32'd1);
    spurious = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("idle_spur_req", 32'(memRequest), 32'd0);
      check("idle_spur_nop", 32'(isNOP), 32'd1);
    end
    spurious = 1'b0;
    enable = 1'b1;
    expect_instr(32'h4);
    drain(10);

    // Enable dropped after the request is issued: the read still completes
    lat = 3; step = 1'b1;
    cycle();
    step = 1'b0;
    expect_instr(32'h8);
    cycle();
    enable = 1'b0;
    #1;
    check("endrop_req", 32'(memRequest), 32'd1);
    check("endrop_addr", memAddress, 32'h8);
    drain(10);

    // Reset during a drain; late memReady afterwards is ignored
    enable = 1'b1; lat = 5;
    jump = 1'b1; jumpAddress = 32'h500;
    cycle();
    jumpAddress = 32'h600;
    cycle();
    jump = 1'b0;
    check("prerst_addr", memAddress, 32'h500);
    check("prerst_req", 32'(memRequest), 32'd1);
    rst = 1'b1; enable = 1'b0;
    #1;
    check("rst_cycle_req", 32'(memRequest), 32'd0);
    cycle();
    check("rstf_pc", programCounter, 32'h0);
    check("rstf_nop", 32'(isNOP), 32'd1);
    rst = 1'b0; spurious = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("late_nop", 32'(isNOP), 32'd1);
      check("late_req", 32'(memRequest), 32'd0);
      check("late_pc", programCounter, 32'h0);
    end
    spurious = 1'b0;
    lat = 0; enable = 1'b1;
    expect_instr(32'h0);
    drain(10);

    check("sb_final", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
